// File: rtl/mem_burst_engine.sv
// Burst sequencer feeding memory_controller: sequential byte reads through a credit-limited FIFO, one write per beat.
// First read byte appears 3 cycles after the first mem_re; rd_ready stalls reads via credits, wr_ready paces writes.
module mem_burst_engine #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 11,
  parameter int BANK_W     = 5,
  parameter int NUM_BANKS  = 19,
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [BANK_W-1:0] mem_bank_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, READ, WRITE, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              cmd_ready_q, busy_q, done_q;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, issued_q, delivered_q, delivered_d;
  logic [CNT_W-1:0]  inflight_q, count_q;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [CNT_W:0]    credit_used;
  logic              issue, push, pop, mem_access;

  // Credits cover both buffered bytes and reads still in the controller pipeline.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue       = (state_q == READ) && (issued_q != len_q) &&
                       (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign wr_ready    = (state_q == WRITE) && (issued_q != len_q);
  assign mem_we      = wr_valid && wr_ready;
  assign mem_re      = issue;
  assign mem_access  = issue || mem_we;
  assign push        = mem_rvalid && (inflight_q != '0);
  assign rd_valid    = (count_q != '0);
  assign pop         = rd_valid && rd_ready;
  assign delivered_d = delivered_q + LEN_W'(pop);

  assign mem_bank_sel = mem_access ? bank_q : '0;
  assign mem_addr     = mem_access ? addr_q : '0;
  assign mem_wdata    = mem_we ? wr_data : '0;
  assign rd_data      = rd_valid ? fifo_q[rptr_q] : '0;
  assign rd_last      = rd_valid && (delivered_q == len_q - LEN_W'(1));
  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;

  always_comb begin
    addr_d = addr_q + ADDR_W'(1);
    bank_d = bank_q;
    if (addr_q == '1) begin
      bank_d = (bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : bank_q + BANK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bank_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (mem_access) begin
        bank_q   <= bank_d;
        addr_q   <= addr_d;
        issued_q <= issued_q + LEN_W'(1);
      end
      if (issue && !push) begin
        inflight_q <= inflight_q + CNT_W'(1);
      end else if (push && !issue) begin
        inflight_q <= inflight_q - CNT_W'(1);
      end
      if (push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q      <= rptr_q + PTR_W'(1);
        delivered_q <= delivered_d;
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            bank_q      <= cmd_bank;
            addr_q      <= cmd_addr;
            len_q       <= cmd_len;
            issued_q    <= '0;
            delivered_q <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (cmd_write) begin
              state_q <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (issue && (issued_q + LEN_W'(1) == len_q)) begin
            state_q <= DRAIN;
          end
        end
        WRITE: begin
          if (mem_we && (issued_q + LEN_W'(1) == len_q)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if ((inflight_q == '0) && (delivered_d == len_q)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_engine.sv
// Directed bench for mem_burst_engine with a two-cycle controller model and a decoupled scoreboard monitor.
module tb_mem_burst_engine;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [4:0]  cmd_bank = '0;
  logic [10:0] cmd_addr = '0;
  logic [11:0] cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [7:0]  wr_data = '0;
  logic        rd_valid, rd_ready = 1'b1, rd_last;
  logic [7:0]  rd_data;
  logic        mem_we, mem_re;
  logic [4:0]  mem_bank_sel;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        busy, done;

  mem_burst_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mem_we(mem_we), .mem_re(mem_re), .mem_bank_sel(mem_bank_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mdata(input logic [4:0] b, input logic [10:0] a);
    return 8'(a * 3 + b * 17 + 1);
  endfunction

  // Controller model: read data returned two cycles after mem_re.
  logic       p1_v = 1'b0, p2_v = 1'b0;
  logic [7:0] p1_d = '0, p2_d = '0;
  always @(posedge clk) begin
    p1_v <= mem_re;
    p1_d <= mdata(mem_bank_sel, mem_addr);
    p2_v <= p1_v;
    p2_d <= p1_d;
  end
  assign mem_rvalid = p2_v;
  assign mem_rdata  = p2_v ? p2_d : 8'h00;

  typedef struct {logic we; logic [4:0] bank; logic [10:0] addr; logic [7:0] wdata;} mreq_t;
  typedef struct {logic [7:0] data; logic last;} rbeat_t;
  mreq_t  exp_mem[$];
  rbeat_t exp_rd[$];

  int total = 0, bad = 0;
  int first_acc = -1, last_acc = -1, first_rdv = -1, done_cyc = -1;
  int done_cnt = 0, rd_hs_cnt = 0, outstanding = 0;
  bit toggle_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an access or a read beat.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("re_we_exclusive", {31'd0, mem_re && mem_we}, 0);
      if (mem_re || mem_we) begin
        if (exp_mem.size() == 0) begin
          fail("mem_unexpected");
        end else begin
          mreq_t e;
          e = exp_mem.pop_front();
          check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          check("mem_bank", {27'd0, mem_bank_sel}, {27'd0, e.bank});
          check("mem_addr", {21'd0, mem_addr}, {21'd0, e.addr});
          if (e.we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
        end
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (mem_re) outstanding++;
      end else begin
        check("idle_bus_zero", {8'd0, mem_bank_sel, mem_addr, mem_wdata}, 0);
      end
      if (rd_valid && first_rdv < 0) first_rdv = cyc;
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          fail("rd_unexpected");
        end else begin
          rbeat_t r;
          r = exp_rd.pop_front();
          check("rd_data", {24'd0, rd_data}, {24'd0, r.data});
          check("rd_last", {31'd0, rd_last}, {31'd0, r.last});
        end
        outstanding--;
        rd_hs_cnt++;
      end
      check("outstanding_le_depth", {31'd0, outstanding <= DEPTH}, 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rd_ready = toggle_rdy ? (cyc % 3 == 0) : 1'b1;
  end

  task automatic send_cmd(input logic w, input logic [4:0] b, input logic [10:0] a,
                          input logic [11:0] l, output int t);
    first_acc = -1; last_acc = -1; first_rdv = -1; done_cyc = -1;
    cmd_valid = 1'b1; cmd_write = w; cmd_bank = b; cmd_addr = a; cmd_len = l;
    t = cyc;
    @(negedge clk);
    check("cmd_ready_at_issue", {31'd0, cmd_ready}, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int start = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == start; i++) @(posedge clk);
    #1;
    if (done_cnt == start) fail(name);
  endtask

  task automatic drive_wr(input logic [7:0] d);
    bit hs = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int n = 0; n < 20 && !hs; n++) begin
      @(negedge clk);
      hs = wr_ready;
      @(posedge clk);
      #1;
    end
    if (!hs) fail("wr_handshake_timeout");
    wr_valid = 1'b0;
  endtask

  task automatic exp_read(input logic [4:0] b, input logic [10:0] a, input logic last);
    exp_mem.push_back('{we: 1'b0, bank: b, addr: a, wdata: 8'h00});
    exp_rd.push_back('{data: mdata(b, a), last: last});
  endtask

  task automatic queues_empty(input string name);
    check({name, "_memq_empty"}, exp_mem.size(), 0);
    check({name, "_rdq_empty"}, exp_rd.size(), 0);
  endtask

  initial begin
    int t, saved_done, base;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_wr_ready", {31'd0, wr_ready}, 0);
    check("rst_mem_re_we", {30'd0, mem_re, mem_we}, 0);
    @(posedge clk);
    #1;

    // Read bank 3, 0x010, len 8
    for (int i = 0; i < 8; i++) exp_read(5'd3, 11'h010 + 11'(i), i == 7);
    send_cmd(1'b0, 5'd3, 11'h010, 12'd8, t);
    wait_done(40, "rd8_done_timeout");
    check("rd8_first_re", first_acc, t + 1);
    check("rd8_last_re", last_acc, t + 8);
    check("rd8_first_rd_valid", first_rdv, t + 4);
    check("rd8_done_cycle", done_cyc, t + 12);
    queues_empty("rd8");

    // Write bank 0, 0x7FE, len 4, crossing into bank 1
    exp_mem.push_back('{we: 1'b1, bank: 5'd0, addr: 11'h7FE, wdata: 8'hA0});
    exp_mem.push_back('{we: 1'b1, bank: 5'd0, addr: 11'h7FF, wdata: 8'hA1});
    exp_mem.push_back('{we: 1'b1, bank: 5'd1, addr: 11'h000, wdata: 8'hA2});
    exp_mem.push_back('{we: 1'b1, bank: 5'd1, addr: 11'h001, wdata: 8'hA3});
    send_cmd(1'b1, 5'd0, 11'h7FE, 12'd4, t);
    for (int i = 0; i < 4; i++) drive_wr(8'hA0 + 8'(i));
    wait_done(20, "wr4_done_timeout");
    check("wr4_last_we", last_acc, t + 4);
    check("wr4_done_cycle", done_cyc, t + 5);
    queues_empty("wr4");

    // Read len 16 with rd_ready high one cycle in three
    toggle_rdy = 1'b1;
    for (int i = 0; i < 16; i++) exp_read(5'd5, 11'h100 + 11'(i), i == 15);
    send_cmd(1'b0, 5'd5, 11'h100, 12'd16, t);
    wait_done(200, "rd16_done_timeout");
    queues_empty("rd16");
    toggle_rdy = 1'b0;
    @(posedge clk);
    #1;

    // Zero-length command
    send_cmd(1'b0, 5'd2, 11'h005, 12'd0, t);
    @(negedge clk);
    check("len0_done", {31'd0, done}, 1);
    check("len0_cmd_ready_low", {31'd0, cmd_ready}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("len0_cmd_ready_back", {31'd0, cmd_ready}, 1);
    check("len0_done_one_cycle", {31'd0, done}, 0);
    check("len0_no_access", first_acc, -1);
    @(posedge clk);
    #1;

    // Last bank, last offset: wraps to bank 0, offset 0
    exp_read(5'd18, 11'h7FF, 1'b0);
    exp_read(5'd0, 11'h000, 1'b1);
    send_cmd(1'b0, 5'd18, 11'h7FF, 12'd2, t);
    wait_done(20, "wrap_done_timeout");
    check("wrap_done_cycle", done_cyc, t + 6);
    queues_empty("wrap");

    // Reset after three delivered beats of a read
    for (int i = 0; i < 8; i++) exp_read(5'd7, 11'h020 + 11'(i), i == 7);
    saved_done = done_cnt;
    base = rd_hs_cnt;
    send_cmd(1'b0, 5'd7, 11'h020, 12'd8, t);
    for (int i = 0; i < 40 && rd_hs_cnt < base + 3; i++) @(posedge clk);
    #1;
    check("mid_rst_beats_seen", rd_hs_cnt - base, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_valid", {31'd0, rd_valid}, 0);
    check("mid_rst_mem_re", {31'd0, mem_re}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("mid_rst_rd_data", {24'd0, rd_data}, 0);
    exp_mem.delete();
    exp_rd.delete();
    outstanding = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rd_valid", {31'd0, rd_valid}, 0);
    end
    check("post_rst_no_done", done_cnt, saved_done);
    @(posedge clk);
    #1;
    exp_read(5'd7, 11'h040, 1'b0);
    exp_read(5'd7, 11'h041, 1'b1);
    send_cmd(1'b0, 5'd7, 11'h040, 12'd2, t);
    wait_done(20, "post_rst_done_timeout");
    check("post_rst_first_rd_valid", first_rdv, t + 4);
    check("post_rst_done_cycle", done_cyc, t + 6);
    queues_empty("post_rst");

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
